// File: rtl/display_scanout.sv
// display_scanout
//   VGA-style raster generator that scans a 1bpp framebuffer out through a
//   centred 512x256 window. The framebuffer is either 64x32 (lores, 8x scale)
//   or 128x64 (hires, 4x scale). It is read as 16-bit words, with bit 15 as
//   the leftmost pixel of each word.
//   Each word is requested 8 pixels before its screen column starts, so the
//   read has finished by the time the word is needed, at any pix_ce duty
//   from 1/1 to 1/8.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   pix_ce     pixel clock enable; the raster advances only on enabled edges
//   hires      mode select (1 = 128x64, 0 = 64x32), sampled at frame start
//   fb_addr    framebuffer word address
//   fb_en      one-clk framebuffer read strobe
//   fb_data    read data, valid one clk after fb_addr/fb_en
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   de         visible-area flag
//   pixel      lit framebuffer pixel (0 outside the window)
//   in_window  raster is inside the framebuffer window
//   frame_tick one-clk pulse at the start of vblank
module display_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  // Window origin; must be at least 8 so the first fetch lands on the line.
  parameter int WIN_X0    = 64,
  parameter int WIN_Y0    = 112
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        hires,
  output logic [8:0]  fb_addr,
  output logic        fb_en,
  input  logic [15:0] fb_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
  output logic        in_window,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] WX0      = 10'(WIN_X0);
  localparam logic [9:0] WX1      = 10'(WIN_X0 + 511);
  localparam logic [9:0] WY0      = 10'(WIN_Y0);
  localparam logic [9:0] WY1      = 10'(WIN_Y0 + 255);
  localparam logic [9:0] FETCH_H0 = 10'(WIN_X0 - 8);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        hires_q, hires_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic        pixel_q, pixel_d, in_window_q, in_window_d;
  logic        frame_tick_q, frame_tick_d;
  logic        fb_en_q, fb_en_d, cap_q, cap_d;
  logic [8:0]  fb_addr_q, fb_addr_d;
  logic [15:0] prefetch_q, prefetch_d, cur_word_q, cur_word_d;

  logic        h_win, v_win, h_lead, fetch_slot, load_slot, pix_bit;
  logic [10:0] hoff_w;
  logic [4:0]  hsub;
  logic [5:0]  vsub;
  logic [3:0]  bit_idx;
  logic [8:0]  word_addr;

  // hoff_w is h relative to the first fetch slot of the line. Bit 10 set
  // means h is left of that slot; bit 9 set means h is past all word columns.
  // Every column (fetch at offset 0, load at offset 7) sits inside 0..511.
  always_comb begin
    h_win   = (h_q >= WX0) && (h_q <= WX1);
    v_win   = (v_q >= WY0) && (v_q <= WY1);
    hoff_w  = {1'b0, h_q} - {1'b0, FETCH_H0};
    h_lead  = !hoff_w[10] && !hoff_w[9];
    hsub    = 5'((h_q - WX0) >> 2);
    vsub    = 6'((v_q - WY0) >> 2);
    if (hires_q) begin
      fetch_slot = h_lead && (hoff_w[5:0] == 6'd0);
      load_slot  = h_lead && (hoff_w[5:0] == 6'd7);
      word_addr  = {vsub[5:0], hoff_w[8:6]};
      bit_idx    = hsub[3:0];
    end else begin
      fetch_slot = h_lead && (hoff_w[6:0] == 7'd0);
      load_slot  = h_lead && (hoff_w[6:0] == 7'd7);
      word_addr  = {2'b00, vsub[5:1], hoff_w[8:7]};
      bit_idx    = hsub[4:1];
    end
    pix_bit = cur_word_q[4'd15 - bit_idx];
  end

  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    hires_d      = hires_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    de_d         = de_q;
    pixel_d      = pixel_q;
    in_window_d  = in_window_q;
    frame_tick_d = 1'b0;
    fb_en_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    cur_word_d   = cur_word_q;
    // The read data arrives one clk after the strobe, so it is captured on
    // the second clk after issue, whether or not pix_ce is set.
    cap_d        = fb_en_q;
    prefetch_d   = cap_q ? fb_data : prefetch_q;
    if (pix_ce) begin
      h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
      if ((h_q == 10'd0) && (v_q == 10'd0)) begin
        hires_d = hires;
      end
      de_d         = (h_q < H_VIS) && (v_q < V_VIS);
      hsync_d      = !((h_q >= HS_LO) && (h_q <= HS_HI));
      vsync_d      = !((v_q >= VS_LO) && (v_q <= VS_HI));
      in_window_d  = h_win && v_win;
      pixel_d      = h_win && v_win && pix_bit;
      frame_tick_d = (h_q == 10'd0) && (v_q == V_VIS);
      if (fetch_slot && v_win) begin
        fb_en_d   = 1'b1;
        fb_addr_d = word_addr;
      end
      if (load_slot) begin
        cur_word_d = prefetch_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      hires_q      <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      pixel_q      <= 1'b0;
      in_window_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      fb_en_q      <= 1'b0;
      cap_q        <= 1'b0;
      fb_addr_q    <= '0;
      prefetch_q   <= '0;
      cur_word_q   <= '0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hires_q      <= hires_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      pixel_q      <= pixel_d;
      in_window_q  <= in_window_d;
      frame_tick_q <= frame_tick_d;
      fb_en_q      <= fb_en_d;
      cap_q        <= cap_d;
      fb_addr_q    <= fb_addr_d;
      prefetch_q   <= prefetch_d;
      cur_word_q   <= cur_word_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_en      = fb_en_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign pixel      = pixel_q;
  assign in_window  = in_window_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scanout.sv
// tb_display_scanout
//   Bench for display_scanout using a shortened raster: a 536x22 frame, a
//   window origin of (8,2), and a full-width 512-pixel window.
//   Hand-derived timing for this geometry:
//     hsync low for h 524..531, vsync low for v 18..19, de when h<520 && v<16,
//     frame_tick on the edge at (h=0, v=16), frame length 11792 pixels.
//   The stimulus pushes the expected video word for every pix_ce edge. At the
//   start of each window line it also pushes that line's word addresses.
//   Two monitors pop these entries when the DUT updates its outputs or
//   strobes fb_en.
module tb_display_scanout;

  localparam int WX = 8;
  localparam int WY = 2;
  localparam int HT = 536;
  localparam int VT = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        hires = 1'b0;
  logic [8:0]  fb_addr;
  logic        fb_en;
  logic [15:0] fb_data = '0;
  logic        hsync, vsync, de, pixel, in_window, frame_tick;

  always #5 clk = ~clk;

  display_scanout #(
    .H_VISIBLE(520), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(16),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .WIN_X0(WX), .WIN_Y0(WY)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hires(hires),
    .fb_addr(fb_addr), .fb_en(fb_en), .fb_data(fb_data),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
    .in_window(in_window), .frame_tick(frame_tick)
  );

  // Framebuffer RAM model with a one-clk read latency.
  logic [15:0] mem [512];
  always @(posedge clk) if (fb_en) fb_data <= mem[fb_addr];

  typedef struct { int x0, x1, y0, y1; } rect_t;
  typedef struct { int h, v; logic [5:0] bits; } exp_t;

  rect_t      rects[$];
  rect_t      next_rects[$];
  exp_t       pix_q[$];
  logic [8:0] addr_q[$];
  int         checks = 0;
  int         errors = 0;
  int         bh, bv, frame;
  logic       exp_hires, next_hires;
  int         cyc = 0;
  int         tick_cnt = 0;
  int         tick_prev = 0;
  int         tick_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic add_rect(input bit to_next, input int x0, input int x1, input int y0, input int y1);
    rect_t r;
    r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1;
    if (to_next) next_rects.push_back(r);
    else rects.push_back(r);
  endtask

  // Expected {pixel, in_window, de, hsync, vsync, frame_tick} for the edge at (h, v).
  function automatic exp_t expect_at(input int h, input int v);
    exp_t e;
    logic lit = 1'b0;
    foreach (rects[i])
      if (h >= rects[i].x0 && h <= rects[i].x1 && v >= rects[i].y0 && v <= rects[i].y1) lit = 1'b1;
    e.h = h;
    e.v = v;
    e.bits = {lit,
              (h >= 8 && h <= 519 && v >= 2 && v <= 257),
              (h < 520 && v < 16),
              !(h >= 524 && h <= 531),
              !(v >= 18 && v <= 19),
              (h == 0 && v == 16)};
    return e;
  endfunction

  // One pix_ce edge, followed by div-1 idle clocks. Starts and ends at a negedge.
  task automatic step(input int div);
    pix_ce = 1'b1;
    pix_q.push_back(expect_at(bh, bv));
    if (bh == 0 && bv >= WY && bv <= WY + 255) begin
      if (exp_hires) for (int k = 0; k < 8; k++) addr_q.push_back(9'(((bv - WY) / 4) * 8 + k));
      else           for (int k = 0; k < 4; k++) addr_q.push_back(9'(((bv - WY) / 8) * 4 + k));
    end
    @(negedge clk);
    bh++;
    if (bh == HT) begin
      bh = 0;
      bv++;
      if (bv == VT) begin
        bv = 0;
        frame++;
        rects = next_rects;
        exp_hires = next_hires;
      end
    end
    if (div > 1) begin
      pix_ce = 1'b0;
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic run_until(input int div, input int th, input int tv, input int tf);
    int n = 0;
    while (!(bh == th && bv == tv && frame == tf) && n < 60000) begin
      step(div);
      n++;
    end
    pix_ce = 1'b0;
    check($sformatf("run_until(%0d,%0d) reached", th, tv), (n < 60000), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " hsync"}, hsync, 1);
    check({tag, " vsync"}, vsync, 1);
    check({tag, " de"}, de, 0);
    check({tag, " pixel"}, pixel, 0);
    check({tag, " in_window"}, in_window, 0);
    check({tag, " frame_tick"}, frame_tick, 0);
    check({tag, " fb_en"}, fb_en, 0);
    check({tag, " fb_addr"}, fb_addr, 0);
  endtask

  task automatic end_checks(input string tag);
    check({tag, " pixel queue drained"}, pix_q.size(), 0);
    check({tag, " address queue drained"}, addr_q.size(), 0);
  endtask

  task automatic start_test(input logic hi);
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    rects.delete();
    next_rects.delete();
    pix_q.delete();
    addr_q.delete();
    hires = hi;
    exp_hires = hi;
    next_hires = hi;
    bh = 0; bv = 0; frame = 0;
  endtask

  // Video monitor: one scoreboard entry per pix_ce edge; frame_tick must be low otherwise.
  logic mon_ce, mon_rst;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_ce = pix_ce;
    mon_rst = reset;
    #1;
    if (!mon_rst && !reset) begin
      if (frame_tick) begin
        tick_cnt++;
        tick_prev = tick_last;
        tick_last = cyc;
      end
      if (mon_ce) begin
        if (pix_q.size() == 0) check("video output without expected entry", 1, 0);
        else begin
          mon_e = pix_q.pop_front();
          check($sformatf("video {pix,win,de,hs,vs,tick} h=%0d v=%0d", mon_e.h, mon_e.v),
                {26'b0, pixel, in_window, de, hsync, vsync, frame_tick}, {26'b0, mon_e.bits});
        end
      end else begin
        check("frame_tick width", frame_tick, 0);
      end
    end
  end

  // Fetch monitor: every fb_en strobe must match the next expected address.
  always @(posedge clk) begin
    #1;
    if (!reset && fb_en) begin
      if (addr_q.size() == 0) check($sformatf("unexpected fetch addr=%0d", fb_addr), 1, 0);
      else check("fb_addr", fb_addr, addr_q.pop_front());
    end
  end

  initial begin
    int t0, n;

    // A: pix_ce every clk. Frame 0 is lores; hires is raised at v=3 and
    // must first take effect in frame 1.
    start_test(1'b0);
    check_reset_vals("power-on reset");
    mem[0] = 16'h8000;
    mem[7] = 16'h0001;
    add_rect(0, 8, 15, 2, 9);
    add_rect(0, 512, 519, 10, 17);
    add_rect(1, 8, 11, 2, 5);
    add_rect(1, 516, 519, 2, 5);
    next_hires = 1'b1;
    reset = 1'b0;
    run_until(1, 0, 3, 0);
    hires = 1'b1;
    run_until(1, 500, 16, 1);
    check("frame_tick interval clks", tick_last - tick_prev, 11792);
    end_checks("A");

    // B: lores with pix_ce 1-of-4, including a word on the second fetch row.
    start_test(1'b0);
    mem[0] = 16'h8000;
    mem[5] = 16'h0001;
    add_rect(0, 8, 15, 2, 9);
    add_rect(0, 256, 263, 10, 17);
    next_rects = rects;
    reset = 1'b0;
    run_until(4, 500, 10, 0);
    end_checks("B");

    // C: hires with pix_ce 1-of-4; hires is already high when the scan starts.
    start_test(1'b1);
    mem[7] = 16'h0001;
    mem[8] = 16'h8000;
    add_rect(0, 516, 519, 2, 5);
    add_rect(0, 8, 11, 6, 9);
    next_rects = rects;
    reset = 1'b0;
    run_until(4, 500, 6, 0);
    end_checks("C");

    // D: reset while the read for word 2 of line 4 is in flight; the scan
    // then restarts from (0,0).
    start_test(1'b0);
    mem[0] = 16'h8000;
    mem[2] = 16'hFFFF;
    add_rect(0, 8, 15, 2, 9);
    add_rect(0, 264, 391, 2, 9);
    next_rects = rects;
    reset = 1'b0;
    run_until(1, 257, 4, 0);
    check("fb_en high before mid-fetch reset", fb_en, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid-frame reset");
    pix_q.delete();
    addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    bh = 0; bv = 0; frame = 0;
    reset = 1'b0;
    t0 = tick_cnt;
    n = 0;
    while (tick_cnt == t0 && n < 20000) begin
      step(1);
      n++;
    end
    check("pix_ce edges from first scan edge to frame_tick", n - 1, 16 * 536);
    run_until(1, 500, 16, 0);
    end_checks("D");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanout.md
DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 SHALL have parameters: H_VISIBLE 640, visible pixels/line; H_FRONT 16; H_SYNC 96; H_BACK 48; V_VISIBLE 480, visible lines; V_FRONT 10; V_SYNC 2; V_BACK 33.
REQ-003 Ports, in order:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- pix_ce  in  1  pixel clock enable
- hires  in  1  1 = 128x64 framebuffer, 0 = 64x32
- fb_addr  out  9  framebuffer read address; blitter word layout, bit 15 = leftmost pixel
- fb_en  out  1  framebuffer read enable
- fb_data  in  16  read data, valid one clk after fb_addr/fb_en register
- hsync  out  1  active low
- vsync  out  1  active low
- de  out  1  visible-area flag
- pixel  out  1  lit framebuffer pixel
- in_window  out  1  inside the 512x256 framebuffer window
- frame_tick  out  1  one-clk pulse at vblank start (60 Hz timer source)

Function
REQ-004 hcount (0..799) and vcount (0..524) SHALL advance only on clk edges with pix_ce=1; hcount wraps to 0 and increments vcount; vcount wraps to 0 after 524.
REQ-005 All video outputs SHALL be registered on pix_ce edges and reflect the pre-increment counters.
REQ-006 Video outputs: de = h<640 && v<480; hsync=0 for h 656..751; vsync=0 for v 490..491.
REQ-007 Window SHALL be h 64..575, v 112..367; in_window follows it; pixel=0 outside the window.
REQ-008 Scale factor SHALL be S=8 for lores and S=4 for hires; fb_y=(v-112)/S; fb_x=(h-64)/S.
REQ-009 Word column width SHALL be W=16*S screen pixels; columns start at B_k=64+k*W, k=0..3 (lores) or 0..7 (hires).
REQ-010 Word address SHALL be fb_y*4+k (lores) or fb_y*8+k (hires), 9-bit.
REQ-011 Fetch SHALL be issued on the pix_ce edge with h==B_k-8 on a window line: fb_addr=address, fb_en=1 for exactly one clk.
REQ-012 fb_data SHALL be captured into a prefetch register on the second clk after issue, independent of pix_ce.
REQ-013 The current-word register SHALL load from prefetch on the pix_ce edge with h==B_k-1.
REQ-014 pixel SHALL equal current_word[15-((h-64)/S mod 16)] inside the window.
REQ-015 Fetch timing SHALL be correct for any pix_ce duty from 1/1 to 1/8.
REQ-016 The hires input SHALL be latched only on the pix_ce edge with h==0, v==0; a mid-frame change takes effect from the next frame.
REQ-017 frame_tick SHALL pulse high for one clk on the pix_ce edge with h==0, v==480.
REQ-018 No fetch SHALL occur on lines outside 112..367; fb_en stays 0 there.

Reset
REQ-019 While reset=1 (asynchronous): hcount=vcount=0, hsync=vsync=1, de=0, pixel=0, in_window=0, frame_tick=0, fb_en=0, fb_addr=0, latched hires=0, prefetch=current_word=0.
REQ-020 After reset deasserts, scan SHALL start at h=0, v=0 on the first pix_ce; reset mid-fetch discards the fetch.

Verification
REQ-021 Sync timing, pix_ce=1: hsync low exactly 96 pix_ce per line (h 656..751); vsync low lines 490..491; frame_tick interval 420000 clks.
REQ-022 Lores: word0=0x8000, all other words 0 -> pixel=1 only for h 64..71, v 112..119; fb_addr sequence on v=112 is 0,1,2,3.
REQ-023 Hires: word7=0x0001 -> pixel=1 only for h 572..575, v 112..115; fb_addr sequence on v=112 is 0..7.
REQ-024 pix_ce 1-of-4 with a RAM model of 1-clk latency -> same pixel maps as REQ-022/023; no stale-word pixels.
REQ-025 Toggle hires at v=200 -> current frame unchanged; next frame uses the new mode from v=112.
REQ-026 Assert reset at h=300, v=150 -> all outputs at reset values immediately; after release the first frame_tick comes 480*800 pix_ce later.
